// File: rtl/pulse_event_arbiter.sv
// pulse_event_arbiter: round-robin serialiser of per-channel event pulses
// Ports: clk, rst_n (sync, active-low), pulse_in[NUM_CH], en,
//        evt_valid/evt_id/evt_ready (output slot handshake),
//        pending, ovf/ovf_clr (sticky overflow), evt_cnt, drop_cnt
module pulse_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] pulse_in,
  input  logic              en,
  output logic              evt_valid,
  output logic [ID_W-1:0]   evt_id,
  input  logic              evt_ready,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] ovf,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [NUM_CH-1:0]   ovf_q, ovf_d;
  logic [CNT_W-1:0]    ecnt_q, ecnt_d;
  logic [CNT_W-1:0]    dcnt_q, dcnt_d;

  logic [NUM_CH-1:0]   grant;
  logic [NUM_CH-1:0]   drop;
  logic [ID_W-1:0]     gnt_idx;
  logic                found;
  logic                accept;
  logic                load_ok;
  logic                do_grant;

  // Scan upward from the channel after the last grant, wrapping,
  // so the most recently served channel has lowest priority.
  always_comb begin : rr_pick
    int c;
    c       = 0;
    gnt_idx = last_q;
    found   = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = int'(last_q) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && pend_q[c]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(c);
      end
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    id_d     = id_q;
    last_d   = last_q;
    grant    = '0;
    accept   = (state_q == FULL) && evt_ready;
    load_ok  = (state_q == EMPTY) || accept;
    do_grant = en && load_ok && found;

    if (do_grant) begin
      grant[gnt_idx] = 1'b1;
      id_d           = gnt_idx;
      last_d         = gnt_idx;
    end

    unique case (state_q)
      EMPTY: if (do_grant) state_d = FULL;
      FULL: begin
        if (do_grant)       state_d = FULL;
        else if (evt_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    // A pulse coinciding with its channel's grant re-arms pending
    // rather than counting as an overflow.
    drop   = pulse_in & pend_q & ~grant;
    pend_d = (pend_q & ~grant) | pulse_in;
    ovf_d  = (ovf_clr ? '0 : ovf_q) | drop;

    ecnt_d = ecnt_q;
    if (accept && (ecnt_q != '1)) ecnt_d = ecnt_q + 1'b1;

    dcnt_d = dcnt_q;
    if ((|drop) && (dcnt_q != '1)) dcnt_d = dcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      id_q    <= '0;
      last_q  <= ID_W'(NUM_CH - 1);
      pend_q  <= '0;
      ovf_q   <= '0;
      ecnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ecnt_q  <= ecnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign evt_valid = (state_q == FULL);
  assign evt_id    = id_q;
  assign pending   = pend_q;
  assign ovf       = ovf_q;
  assign evt_cnt   = ecnt_q;
  assign drop_cnt  = dcnt_q;

endmodule
